// File: rtl/cam_pkg.sv
// Shared defaults and registered-result types for the parametrised CAM.
package cam_pkg;

   localparam int CAM_WIDTH     = 32;
   localparam int CAM_DEPTH     = 32;
   // Index field is sized for the largest supported array; upper bits stay zero.
   localparam int CAM_MAX_IDX_W = 16;

   typedef struct packed {
      logic                     done;
      logic                     valid;
      logic                     multi;
      logic [CAM_MAX_IDX_W-1:0] index;
   } search_res_t;

   typedef struct packed {
      logic done;
      logic valid;
   } read_res_t;

endpackage

// File: rtl/cam_if.sv
// Request/result bundle between the request datapath and the CAM lookup store.
interface cam_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   localparam int IDX_W = $clog2(DEPTH);

   // Requests are single-cycle strobes accepted unconditionally (no ready);
   // each *_done pulses for exactly one cycle, one cycle after its request.
   logic             read;
   logic [IDX_W-1:0] read_index;
   logic             write;
   logic [IDX_W-1:0] write_index;
   logic [WIDTH-1:0] write_data;
   logic             inval;
   logic [IDX_W-1:0] inval_index;
   logic             flush;
   logic             search;
   logic [WIDTH-1:0] search_data;
   logic [WIDTH-1:0] search_mask;

   logic             read_done;
   logic             read_valid;
   logic [WIDTH-1:0] read_value;
   logic             search_done;
   logic             search_valid;
   logic             search_multi;
   logic [IDX_W-1:0] search_index;
   logic [IDX_W:0]   occupancy;
   logic             full;
   logic             free_valid;
   logic [IDX_W-1:0] free_index;

   modport master (
      output read, read_index, write, write_index, write_data,
             inval, inval_index, flush, search, search_data, search_mask,
      input  read_done, read_valid, read_value, search_done, search_valid,
             search_multi, search_index, occupancy, full, free_valid, free_index
   );

   modport slave (
      input  read, read_index, write, write_index, write_data,
             inval, inval_index, flush, search, search_data, search_mask,
      output read_done, read_valid, read_value, search_done, search_valid,
             search_multi, search_index, occupancy, full, free_valid, free_index
   );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with any-set and multiple-set flags.
module cam_prio_enc #(
   parameter int N  = 32,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          multi
);

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign any   = |req;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/cam_param.sv
// DEPTH x WIDTH flip-flop CAM: masked search, invalidate, flush, multi-hit
// detection and free-slot/occupancy tracking; read/search results registered.
module cam_param
   import cam_pkg::*;
#(
   parameter int WIDTH = CAM_WIDTH,
   parameter int DEPTH = CAM_DEPTH
) (
   input logic  clk,
   input logic  reset_n,
   cam_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_nxt;
   logic [IDX_W:0]   occ_q;

   search_res_t      srch_q;
   read_res_t        rd_q;
   logic [WIDTH-1:0] rd_value_q;

   logic wr_in, inv_in, rd_in;
   logic wr_ok, inv_ok, rd_hit;
   logic occ_inc, occ_dec;
   logic [WIDTH-1:0] rd_word;

   logic [DEPTH-1:0] match;
   logic [IDX_W-1:0] match_idx;
   logic             match_any, match_multi;
   logic [IDX_W-1:0] free_idx;
   logic             free_any;
   logic             unused_free_multi;
   logic             unused_srch_idx;

   // Non-power-of-two depths leave index codes that address no entry.
   if (DEPTH == (1 << IDX_W)) begin : g_pow2
      assign wr_in  = 1'b1;
      assign inv_in = 1'b1;
      assign rd_in  = 1'b1;
   end else begin : g_range
      assign wr_in  = ({1'b0, bus.write_index} < (IDX_W + 1)'(DEPTH));
      assign inv_in = ({1'b0, bus.inval_index} < (IDX_W + 1)'(DEPTH));
      assign rd_in  = ({1'b0, bus.read_index}  < (IDX_W + 1)'(DEPTH));
   end

   assign wr_ok   = bus.write & wr_in;
   assign inv_ok  = bus.inval & inv_in;
   assign occ_inc = wr_ok & ~valid_q[bus.write_index];
   assign occ_dec = inv_ok & valid_q[bus.inval_index] &
                    ~(wr_ok && (bus.write_index == bus.inval_index));

   // Write is applied after inval so a same-index pair leaves the entry valid.
   always_comb begin
      valid_nxt = valid_q;
      if (inv_ok) valid_nxt[bus.inval_index] = 1'b0;
      if (wr_ok)  valid_nxt[bus.write_index] = 1'b1;
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid_q[i] & ~|((mem[i] ^ bus.search_data) & bus.search_mask);
      end
   end

   assign rd_hit = bus.read & rd_in & valid_q[bus.read_index];

   always_comb begin
      rd_word = '0;
      if (rd_hit) rd_word = mem[bus.read_index];
   end

   cam_prio_enc #(.N(DEPTH), .IW(IDX_W)) u_match_enc (
      .req   (match),
      .idx   (match_idx),
      .any   (match_any),
      .multi (match_multi)
   );

   cam_prio_enc #(.N(DEPTH), .IW(IDX_W)) u_free_enc (
      .req   (~valid_q),
      .idx   (free_idx),
      .any   (free_any),
      .multi (unused_free_multi)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         valid_q <= '0;
         occ_q   <= '0;
      end else if (bus.flush) begin
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         if (wr_ok) mem[bus.write_index] <= bus.write_data;
         valid_q <= valid_nxt;
         occ_q   <= occ_q + (IDX_W + 1)'(occ_inc) - (IDX_W + 1)'(occ_dec);
      end
   end

   // Read and search see the array as it was before this edge's updates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q       <= '0;
         rd_value_q <= '0;
         srch_q     <= '0;
      end else begin
         rd_q.done    <= bus.read;
         rd_q.valid   <= rd_hit;
         rd_value_q   <= rd_word;
         srch_q.done  <= bus.search;
         srch_q.valid <= bus.search & match_any;
         srch_q.multi <= bus.search & match_multi;
         srch_q.index <= (bus.search && match_any) ? CAM_MAX_IDX_W'(match_idx) : '0;
      end
   end

   assign unused_srch_idx  = ^srch_q.index;

   assign bus.read_done    = rd_q.done;
   assign bus.read_valid   = rd_q.valid;
   assign bus.read_value   = rd_value_q;
   assign bus.search_done  = srch_q.done;
   assign bus.search_valid = srch_q.valid;
   assign bus.search_multi = srch_q.multi;
   assign bus.search_index = srch_q.index[IDX_W-1:0];
   assign bus.occupancy    = occ_q;
   assign bus.full         = &valid_q;
   assign bus.free_valid   = free_any;
   assign bus.free_index   = free_idx;

endmodule

// File: tb/tb_cam_param.sv
// Directed bench for cam_param: a 32-entry instance plus a 20-entry instance
// for out-of-range index behaviour.
module tb_cam_param;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   cam_if #(.WIDTH(32), .DEPTH(32)) bus ();
   cam_if #(.WIDTH(32), .DEPTH(20)) bus20 ();

   cam_param #(.WIDTH(32), .DEPTH(32)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   cam_param #(.WIDTH(32), .DEPTH(20)) u_dut20 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus20)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.read = 1'b0;   bus.read_index = '0;
      bus.write = 1'b0;  bus.write_index = '0;  bus.write_data = '0;
      bus.inval = 1'b0;  bus.inval_index = '0;
      bus.flush = 1'b0;
      bus.search = 1'b0; bus.search_data = '0;  bus.search_mask = '0;
      bus20.read = 1'b0;   bus20.read_index = '0;
      bus20.write = 1'b0;  bus20.write_index = '0;  bus20.write_data = '0;
      bus20.inval = 1'b0;  bus20.inval_index = '0;
      bus20.flush = 1'b0;
      bus20.search = 1'b0; bus20.search_data = '0;  bus20.search_mask = '0;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] data);
      bus.write = 1'b1; bus.write_index = idx; bus.write_data = data;
      tick();
      clear_reqs();
   endtask

   task automatic rd(input logic [4:0] idx);
      bus.read = 1'b1; bus.read_index = idx;
      tick();
      clear_reqs();
   endtask

   task automatic inv(input logic [4:0] idx);
      bus.inval = 1'b1; bus.inval_index = idx;
      tick();
      clear_reqs();
   endtask

   task automatic srch(input logic [31:0] key, input logic [31:0] mask);
      bus.search = 1'b1; bus.search_data = key; bus.search_mask = mask;
      tick();
      clear_reqs();
   endtask

   task automatic check_search(input string tag, input logic v, input logic m, input logic [4:0] idx);
      check_eq({tag, "_done"},  bus.search_done,  1'b1);
      check_eq({tag, "_valid"}, bus.search_valid, v);
      check_eq({tag, "_multi"}, bus.search_multi, m);
      check_eq({tag, "_index"}, bus.search_index, idx);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      clear_reqs();
      repeat (3) tick();

      check_eq("rst_read_done",   bus.read_done,   1'b0);
      check_eq("rst_search_done", bus.search_done, 1'b0);
      check_eq("rst_occupancy",   bus.occupancy,   6'd0);
      check_eq("rst_free_valid",  bus.free_valid,  1'b1);
      check_eq("rst_free_index",  bus.free_index,  5'd0);
      check_eq("rst_full",        bus.full,        1'b0);
      reset_n = 1'b1;
      tick();

      // basic write / read
      wr(5'd5, 32'hDEAD_BEEF);
      rd(5'd5);
      check_eq("rd5_done",  bus.read_done,  1'b1);
      check_eq("rd5_valid", bus.read_valid, 1'b1);
      check_eq("rd5_value", bus.read_value, 32'hDEAD_BEEF);
      check_eq("rd5_occ",   bus.occupancy,  6'd1);
      check_eq("rd5_free",  bus.free_index, 5'd0);
      tick();
      check_eq("rd_done_one_cycle", bus.read_done, 1'b0);
      rd(5'd6);
      check_eq("rd6_valid", bus.read_valid, 1'b0);
      check_eq("rd6_value", bus.read_value, 32'h0);

      // multi-hit then single hit after inval
      wr(5'd3, 32'h1234_5678);
      wr(5'd9, 32'h1234_5678);
      srch(32'h1234_5678, 32'hFFFF_FFFF);
      check_search("multi", 1'b1, 1'b1, 5'd3);
      inv(5'd3);
      check_eq("inval3_occ", bus.occupancy, 6'd2);
      srch(32'h1234_5678, 32'hFFFF_FFFF);
      check_search("single", 1'b1, 1'b0, 5'd9);

      // masked search
      wr(5'd7, 32'hAB00_0011);
      srch(32'hAB00_FF11, 32'hFFFF_00FF);
      check_search("masked", 1'b1, 1'b0, 5'd7);
      srch(32'hAB00_FF11, 32'hFFFF_FFFF);
      check_search("fullmask", 1'b0, 1'b0, 5'd0);
      srch(32'h0, 32'h0);
      check_search("zeromask", 1'b1, 1'b1, 5'd5);

      // write and search same cycle: no bypass
      wr(5'd2, 32'h5);
      bus.write = 1'b1; bus.write_index = 5'd2; bus.write_data = 32'h1;
      bus.search = 1'b1; bus.search_data = 32'h1; bus.search_mask = 32'hFFFF_FFFF;
      tick();
      clear_reqs();
      check_search("nobypass", 1'b0, 1'b0, 5'd0);
      srch(32'h1, 32'hFFFF_FFFF);
      check_search("after_wr", 1'b1, 1'b0, 5'd2);

      // fill, same-index write+inval, partial inval, flush
      for (int i = 0; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
      check_eq("fill_full",  bus.full,       1'b1);
      check_eq("fill_fv",    bus.free_valid, 1'b0);
      check_eq("fill_occ",   bus.occupancy,  6'd32);
      check_eq("fill_fidx",  bus.free_index, 5'd0);
      bus.write = 1'b1; bus.write_index = 5'd4; bus.write_data = 32'h44;
      bus.inval = 1'b1; bus.inval_index = 5'd4;
      tick();
      clear_reqs();
      check_eq("wrinv_occ",  bus.occupancy, 6'd32);
      rd(5'd4);
      check_eq("wrinv_valid", bus.read_valid, 1'b1);
      check_eq("wrinv_value", bus.read_value, 32'h44);
      inv(5'd10);
      check_eq("inv10_occ",  bus.occupancy,  6'd31);
      check_eq("inv10_full", bus.full,       1'b0);
      check_eq("inv10_fv",   bus.free_valid, 1'b1);
      check_eq("inv10_fidx", bus.free_index, 5'd10);
      inv(5'd10);
      check_eq("reinv_occ",  bus.occupancy,  6'd31);
      bus.flush = 1'b1;
      bus.write = 1'b1; bus.write_index = 5'd0; bus.write_data = 32'h77;
      tick();
      clear_reqs();
      check_eq("flush_occ",  bus.occupancy,  6'd0);
      check_eq("flush_fidx", bus.free_index, 5'd0);
      check_eq("flush_fv",   bus.free_valid, 1'b1);
      rd(5'd0);
      check_eq("flush_rd_valid", bus.read_valid, 1'b0);
      check_eq("flush_rd_value", bus.read_value, 32'h0);
      srch(32'h0, 32'h0);
      check_search("flush_srch", 1'b0, 1'b0, 5'd0);

      // reset between search request and its result
      wr(5'd1, 32'hAB00_0011);
      bus.search = 1'b1; bus.search_data = 32'hAB00_0011; bus.search_mask = 32'hFFFF_FFFF;
      #2 reset_n = 1'b0;
      @(posedge clk);
      #1;
      clear_reqs();
      check_eq("midrst_sdone",  bus.search_done,  1'b0);
      check_eq("midrst_svalid", bus.search_valid, 1'b0);
      check_eq("midrst_sidx",   bus.search_index, 5'd0);
      check_eq("midrst_occ",    bus.occupancy,    6'd0);
      check_eq("midrst_rdone",  bus.read_done,    1'b0);
      tick();
      reset_n = 1'b1;
      tick();

      // 20-entry build: out-of-range indices
      bus20.write = 1'b1; bus20.write_index = 5'd25; bus20.write_data = 32'hCAFE;
      tick();
      clear_reqs();
      check_eq("d20_oor_wr_occ", bus20.occupancy, 6'd0);
      bus20.write = 1'b1; bus20.write_index = 5'd19; bus20.write_data = 32'h1919;
      tick();
      clear_reqs();
      check_eq("d20_occ",  bus20.occupancy,  6'd1);
      check_eq("d20_fidx", bus20.free_index, 5'd0);
      bus20.read = 1'b1; bus20.read_index = 5'd25;
      tick();
      clear_reqs();
      check_eq("d20_oor_done",  bus20.read_done,  1'b1);
      check_eq("d20_oor_valid", bus20.read_valid, 1'b0);
      check_eq("d20_oor_value", bus20.read_value, 32'h0);
      bus20.read = 1'b1; bus20.read_index = 5'd19;
      bus20.inval = 1'b1; bus20.inval_index = 5'd25;
      tick();
      clear_reqs();
      check_eq("d20_rd19_valid", bus20.read_valid, 1'b1);
      check_eq("d20_rd19_value", bus20.read_value, 32'h1919);
      check_eq("d20_oor_inv_occ", bus20.occupancy, 6'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
